// File: rtl/joojump_output_port_if.sv
// Avalon-MM slave bus bundle for the output port.
//   address    : register select (word offset)
//   chipselect : slave selected this cycle
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : registered read data
interface joojump_output_port_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/joojump_output_port.sv
// Memory-mapped output port: data register with atomic set/clear and a
// hardware-timed pulse that inverts masked bits for a programmed number of
// clock cycles.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port : registered output pins
// Register map: 0 DATA, 1 SET, 2 CLEAR, 3 PULSE {count[15:0], mask}.
module joojump_output_port #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   joojump_output_port_if.slave      bus,
   output logic [WIDTH-1:0]          out_port
);

   localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] data_q,     data_d;
   logic [WIDTH-1:0] mask_q,     mask_d;
   logic [15:0]      count_q,    count_d;
   logic [WIDTH-1:0] out_q,      out_d;
   logic [31:0]      readdata_q, readdata_d;

   logic             wr_en;
   logic [WIDTH-1:0] wr_bits;
   logic             unused_writedata;

   assign wr_en   = bus.chipselect & ~bus.write_n;
   assign wr_bits = bus.writedata[WIDTH-1:0];

   // Only the low WIDTH bits and, at PULSE, the top half are meaningful.
   assign unused_writedata = ^bus.writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q     <= RST_VAL;
         mask_q     <= '0;
         count_q    <= '0;
         out_q      <= RST_VAL;
         readdata_q <= '0;
      end else begin
         data_q     <= data_d;
         mask_q     <= mask_d;
         count_q    <= count_d;
         out_q      <= out_d;
         readdata_q <= readdata_d;
      end
   end

   // A PULSE write overrides the free-running decrement in the same cycle,
   // which is what lets software restart or abort a pulse at any time.
   always_comb begin
      data_d  = data_q;
      mask_d  = mask_q;
      count_d = (count_q != 16'd0) ? count_q - 16'd1 : 16'd0;
      if (wr_en) begin
         case (bus.address)
            2'd0: data_d = wr_bits;
            2'd1: data_d = data_q | wr_bits;
            2'd2: data_d = data_q & ~wr_bits;
            default: begin
               mask_d  = wr_bits;
               count_d = bus.writedata[31:16];
            end
         endcase
      end
   end

   // Output is computed from next-state values so a write is visible on
   // the same edge that captures it.
   always_comb begin
      out_d = data_d ^ ((count_d != 16'd0) ? mask_d : '0);
   end

   // Read mux uses current register contents: a write captured on the same
   // edge is not yet visible.
   always_comb begin
      readdata_d = '0;
      case (bus.address)
         2'd0:    readdata_d = 32'(data_q);
         2'd3:    readdata_d = {count_q, 16'd0} | 32'(mask_q);
         default: readdata_d = '0;
      endcase
   end

   assign out_port     = out_q;
   assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_joojump_output_port.sv
module tb_joojump_output_port;

   logic       clk;
   logic       reset;
   logic [7:0] out_port;
   int         tests_run;
   int         tests_failed;

   joojump_output_port_if bus ();

   joojump_output_port #(
      .WIDTH       (8),
      .RESET_VALUE (32'h5A)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle write; on return the capture edge has just passed.
   task automatic bus_write(input logic [1:0] addr, input logic [31:0] wd);
      bus.address    = addr;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = wd;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'h0;
   endtask

   task automatic test_reset();
      bus_write(2'd0, 32'h0000_00AA);
      bus.address = 2'd0;
      tick();
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (out_port !== 8'h5A) begin
         tests_failed++;
         $display("FAIL reset_out: got %h expected %h", out_port, 8'h5A);
      end
      tests_run++;
      if (bus.readdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
      end
      tick();
      reset = 1'b0;
      tick();
      tests_run++;
      if (bus.readdata !== 32'h0000_005A) begin
         tests_failed++;
         $display("FAIL reset_data_read: got %h expected %h", bus.readdata, 32'h5A);
      end
   endtask

   task automatic test_data();
      bus_write(2'd0, 32'hFFFF_FFC3);
      tests_run++;
      if (out_port !== 8'hC3) begin
         tests_failed++;
         $display("FAIL data_out: got %h expected %h", out_port, 8'hC3);
      end
      bus.address = 2'd0;
      tick();
      tests_run++;
      if (bus.readdata !== 32'h0000_00C3) begin
         tests_failed++;
         $display("FAIL data_read: got %h expected %h", bus.readdata, 32'hC3);
      end
   endtask

   task automatic test_set_clear();
      bus_write(2'd0, 32'h0000_000F);
      bus_write(2'd1, 32'h0000_00F0);
      tests_run++;
      if (out_port !== 8'hFF) begin
         tests_failed++;
         $display("FAIL set_out: got %h expected %h", out_port, 8'hFF);
      end
      bus_write(2'd2, 32'h0000_003C);
      tests_run++;
      if (out_port !== 8'hC3) begin
         tests_failed++;
         $display("FAIL clear_out: got %h expected %h", out_port, 8'hC3);
      end
      for (int a = 1; a <= 2; a++) begin
         bus.address = 2'd0;
         tick();
         bus.address = 2'(a);
         tick();
         tests_run++;
         if (bus.readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_addr%0d: got %h expected %h", a, bus.readdata, 32'h0);
         end
      end
   endtask

   task automatic test_pulse();
      bus_write(2'd0, 32'h0);
      bus_write(2'd3, {16'd5, 16'h0081});
      tests_run++;
      if (out_port !== 8'h81) begin
         tests_failed++;
         $display("FAIL pulse_edge0: got %h expected %h", out_port, 8'h81);
      end
      bus.address = 2'd3;
      for (int i = 1; i <= 5; i++) begin
         tick();
         tests_run++;
         if (out_port !== ((i < 5) ? 8'h81 : 8'h00)) begin
            tests_failed++;
            $display("FAIL pulse_edge%0d: got %h expected %h", i, out_port,
                     (i < 5) ? 8'h81 : 8'h00);
         end
         if (i == 3) begin
            tests_run++;
            if (bus.readdata !== 32'h0003_0081) begin
               tests_failed++;
               $display("FAIL pulse_count_read: got %h expected %h", bus.readdata, 32'h0003_0081);
            end
         end
      end
   endtask

   task automatic test_restart();
      bus_write(2'd0, 32'h0);
      bus_write(2'd3, {16'd3, 16'h0001});
      tick();
      tick();
      bus_write(2'd3, {16'd10, 16'h0001});
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) tick();
         tests_run++;
         if (out_port !== ((i < 10) ? 8'h01 : 8'h00)) begin
            tests_failed++;
            $display("FAIL restart_edge%0d: got %h expected %h", i, out_port,
                     (i < 10) ? 8'h01 : 8'h00);
         end
      end
   endtask

   task automatic test_abort();
      bus_write(2'd0, 32'h0);
      bus_write(2'd3, {16'd20, 16'h0001});
      tick();
      tick();
      bus_write(2'd3, {16'd0, 16'h0001});
      tests_run++;
      if (out_port !== 8'h00) begin
         tests_failed++;
         $display("FAIL abort_out: got %h expected %h", out_port, 8'h00);
      end
      bus.address = 2'd3;
      tick();
      tests_run++;
      if (bus.readdata !== 32'h0000_0001) begin
         tests_failed++;
         $display("FAIL abort_read: got %h expected %h", bus.readdata, 32'h1);
      end
   endtask

   task automatic test_reset_mid_pulse();
      bus_write(2'd0, 32'h0);
      bus_write(2'd3, {16'd6, 16'h000F});
      tick();
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (out_port !== 8'h5A) begin
         tests_failed++;
         $display("FAIL rst_pulse_out: got %h expected %h", out_port, 8'h5A);
      end
      tick();
      reset = 1'b0;
      bus.address = 2'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (out_port !== 8'h5A) begin
            tests_failed++;
            $display("FAIL rst_pulse_after%0d: got %h expected %h", i, out_port, 8'h5A);
         end
      end
      tests_run++;
      if (bus.readdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_pulse_count: got %h expected %h", bus.readdata, 32'h0);
      end
   endtask

   task automatic test_data_during_pulse();
      bus_write(2'd0, 32'h0);
      bus_write(2'd3, {16'd4, 16'h0001});
      bus_write(2'd1, 32'h0000_0001);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         tests_run++;
         if (out_port[0] !== ((i < 3) ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("FAIL set_in_pulse_%0d: got %b expected %b", i, out_port[0],
                     (i < 3) ? 1'b0 : 1'b1);
         end
      end
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      reset          = 1'b1;
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tests_run++;
      if (out_port !== 8'h5A) begin
         tests_failed++;
         $display("FAIL initial_out: got %h expected %h", out_port, 8'h5A);
      end
      test_reset();
      test_data();
      test_set_clear();
      test_pulse();
      test_restart();
      test_abort();
      test_reset_mid_pulse();
      test_data_during_pulse();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
